// File: rtl/rr_encoder_n_pkg.sv
// Shared math helpers for the request encoder and the schedulers that reuse its picker.
package rr_encoder_n_pkg;

   // Number of bits needed to hold 'value'; never less than one.
   function automatic int clogb2(input int value);
      int res;
      int v;
      res = 0;
      v   = value;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

   function automatic int index_width(input int size);
      return clogb2(size - 1);
   endfunction

endpackage

// File: rtl/rr_encoder_n_pick.sv
// Combinational picker: first set bit of cand searching upward from ptr (RR=1),
// or lowest set bit (RR=0). Built as rotate, lowest-one detect, rotate back.
module rr_pick_n
   import rr_encoder_n_pkg::*;
#(
   parameter  int SIZE     = 8,
   parameter  int RR       = 1,
   localparam int LOG_SIZE = index_width(SIZE)
) (
   input  logic [SIZE-1:0]     cand,
   input  logic [LOG_SIZE-1:0] ptr,
   output logic [SIZE-1:0]     pick,
   output logic [LOG_SIZE-1:0] index,
   output logic                any
);

   localparam logic [LOG_SIZE:0] SIZE_W = (LOG_SIZE+1)'(SIZE);

   logic [LOG_SIZE-1:0] eff_ptr;
   logic [2*SIZE-1:0]   dbl_dn;
   logic [2*SIZE-1:0]   dbl_up;
   logic [SIZE-1:0]     rot;
   logic [SIZE-1:0]     low;
   logic [LOG_SIZE-1:0] rot_idx;
   logic [LOG_SIZE:0]   sum;

   always_comb begin
      eff_ptr = (RR != 0) ? ptr : '0;
      dbl_dn  = {cand, cand} >> eff_ptr;
      rot     = dbl_dn[SIZE-1:0];
      low     = rot & (~rot + SIZE'(1));
      rot_idx = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (low[i]) rot_idx = LOG_SIZE'(i);
      end
      // Undo the rotation on the index with a modulo-SIZE add (SIZE need not be 2^n).
      sum = {1'b0, rot_idx} + {1'b0, eff_ptr};
      if (sum >= SIZE_W) sum = sum - SIZE_W;
      dbl_up = {low, low} << eff_ptr;
      pick   = dbl_up[2*SIZE-1:SIZE];
      any    = |cand;
      index  = any ? sum[LOG_SIZE-1:0] : '0;
   end

endmodule

// File: rtl/rr_encoder_n.sv
// Registered request-to-index encoder: pending set/clear register, round-robin
// pointer, and a valid/ready output stage that holds under backpressure.
module rr_encoder_n
   import rr_encoder_n_pkg::*;
#(
   parameter  int SIZE     = 8,
   parameter  int RR       = 1,
   localparam int LOG_SIZE = index_width(SIZE)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [SIZE-1:0]     req,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LOG_SIZE-1:0] out_index,
   output logic [SIZE-1:0]     out_grant,
   output logic [SIZE-1:0]     pending
);

   localparam logic [LOG_SIZE-1:0] LAST = LOG_SIZE'(SIZE - 1);

   logic [SIZE-1:0]     pend_q, pend_d;
   logic [LOG_SIZE-1:0] ptr_q, ptr_d;
   logic                valid_q, valid_d;
   logic [LOG_SIZE-1:0] index_q, index_d;
   logic [SIZE-1:0]     grant_q, grant_d;

   logic                hs;
   logic [SIZE-1:0]     cand;
   logic [SIZE-1:0]     pick_oh;
   logic [LOG_SIZE-1:0] pick_idx;
   logic                pick_any;

   always_comb begin
      hs     = valid_q & out_ready;
      cand   = pend_q & ~(hs ? grant_q : '0);
      // Set wins over clear: a same-cycle req re-arms the bit being retired.
      pend_d = cand | req;
      ptr_d  = ptr_q;
      if (RR != 0 && hs) ptr_d = (index_q == LAST) ? '0 : index_q + LOG_SIZE'(1);
   end

   // Selection in the handshake cycle already sees the advanced pointer.
   rr_pick_n #(.SIZE(SIZE), .RR(RR)) u_pick (
      .cand  (cand),
      .ptr   (ptr_d),
      .pick  (pick_oh),
      .index (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      valid_d = valid_q;
      index_d = index_q;
      grant_d = grant_q;
      if (!valid_q || hs) begin
         valid_d = pick_any;
         index_d = pick_idx;
         grant_d = pick_oh;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend_q  <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         grant_q <= '0;
      end else begin
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         index_q <= index_d;
         grant_q <= grant_d;
      end
   end

   assign out_valid = valid_q;
   assign out_index = index_q;
   assign out_grant = grant_q;
   assign pending   = pend_q;

endmodule

// File: tb/tb_rr_encoder_n.sv
// Bench for rr_encoder_n: five configurations against an arithmetic reference model,
// directed scenarios followed by randomized traffic.
module tb_rr_encoder_n;

   localparam int NI = 5;
   localparam int SZ [NI]  = '{8, 8, 5, 16, 2};
   localparam int RRS [NI] = '{1, 0, 1, 1, 1};

   typedef struct {
      bit [15:0] pend;
      int        ptr;
      bit        ov;
      int        idx;
   } mst_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] reqa [NI];
   logic [NI-1:0] rdy;
   logic [NI-1:0] ov;
   logic [15:0] oi [NI];
   logic [15:0] og [NI];
   logic [15:0] op [NI];

   logic [2:0] i0, i1, i2;
   logic [3:0] i3;
   logic [0:0] i4;
   logic [7:0] g0, g1, p0, p1;
   logic [4:0] g2, p2;
   logic [15:0] g3, p3;
   logic [1:0] g4, p4;

   mst_t m [NI];
   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] prev;

   always #5 clock = ~clock;

   rr_encoder_n #(.SIZE(8),  .RR(1)) u0 (.clock(clock), .reset_n(reset_n), .req(reqa[0][7:0]),
      .out_valid(ov[0]), .out_ready(rdy[0]), .out_index(i0), .out_grant(g0), .pending(p0));
   rr_encoder_n #(.SIZE(8),  .RR(0)) u1 (.clock(clock), .reset_n(reset_n), .req(reqa[1][7:0]),
      .out_valid(ov[1]), .out_ready(rdy[1]), .out_index(i1), .out_grant(g1), .pending(p1));
   rr_encoder_n #(.SIZE(5),  .RR(1)) u2 (.clock(clock), .reset_n(reset_n), .req(reqa[2][4:0]),
      .out_valid(ov[2]), .out_ready(rdy[2]), .out_index(i2), .out_grant(g2), .pending(p2));
   rr_encoder_n #(.SIZE(16), .RR(1)) u3 (.clock(clock), .reset_n(reset_n), .req(reqa[3]),
      .out_valid(ov[3]), .out_ready(rdy[3]), .out_index(i3), .out_grant(g3), .pending(p3));
   rr_encoder_n #(.SIZE(2),  .RR(1)) u4 (.clock(clock), .reset_n(reset_n), .req(reqa[4][1:0]),
      .out_valid(ov[4]), .out_ready(rdy[4]), .out_index(i4), .out_grant(g4), .pending(p4));

   assign oi[0] = 16'(i0);  assign og[0] = 16'(g0);  assign op[0] = 16'(p0);
   assign oi[1] = 16'(i1);  assign og[1] = 16'(g1);  assign op[1] = 16'(p1);
   assign oi[2] = 16'(i2);  assign og[2] = 16'(g2);  assign op[2] = 16'(p2);
   assign oi[3] = i3;       assign og[3] = g3;       assign op[3] = p3;
   assign oi[4] = 16'(i4);  assign og[4] = 16'(g4);  assign op[4] = 16'(p4);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic mst_t mzero();
      mst_t z;
      z.pend = '0; z.ptr = 0; z.ov = 1'b0; z.idx = 0;
      return z;
   endfunction

   // Reference: retire granted bit on handshake, OR in requests, then scan for the
   // next winner starting at the round-robin pointer (or at 0 for fixed priority).
   function automatic mst_t mstep(input mst_t s, input int size, input int rr,
                                  input bit [15:0] req, input bit rdy_i);
      mst_t n;
      bit [15:0] cand;
      bit hs;
      int j;
      n    = s;
      hs   = s.ov && rdy_i;
      cand = s.pend;
      if (hs) begin
         cand[s.idx] = 1'b0;
         if (rr != 0) n.ptr = (s.idx + 1) % size;
      end
      n.pend = cand | (req & 16'((32'd1 << size) - 1));
      if (!s.ov || hs) begin
         n.ov  = 1'b0;
         n.idx = 0;
         for (int i = 0; i < size; i++) begin
            j = (rr != 0) ? (n.ptr + i) % size : i;
            if (cand[j]) begin
               n.ov  = 1'b1;
               n.idx = j;
               break;
            end
         end
      end
      return n;
   endfunction

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("u%0d.valid", k), 32'(ov[k]), 32'(m[k].ov));
         chk($sformatf("u%0d.index", k), 32'(oi[k]), 32'(m[k].idx));
         chk($sformatf("u%0d.grant", k), 32'(og[k]), m[k].ov ? (32'd1 << m[k].idx) : 32'd0);
         chk($sformatf("u%0d.pending", k), 32'(op[k]), 32'(m[k].pend));
      end
   endtask

   task automatic tick();
      @(posedge clock);
      for (int k = 0; k < NI; k++)
         m[k] = reset_n ? mstep(m[k], SZ[k], RRS[k], reqa[k], rdy[k]) : mzero();
      #1;
      check_all();
   endtask

   task automatic clr_req();
      for (int k = 0; k < NI; k++) reqa[k] = '0;
   endtask

   initial begin
      clr_req();
      rdy = '1;
      for (int k = 0; k < NI; k++) m[k] = mzero();
      tick();
      tick();
      chk("reset.valid_u0", 32'(ov[0]), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Fixed priority drains A4 as 2, 5, 7.
      reqa[1] = 16'h00A4;
      tick();
      clr_req();
      chk("t1.pending", 32'(op[1]), 32'hA4);
      tick();
      chk("t1.idx_a", 32'(oi[1]), 32'd2);
      tick();
      chk("t1.idx_b", 32'(oi[1]), 32'd5);
      tick();
      chk("t1.idx_c", 32'(oi[1]), 32'd7);
      tick();
      chk("t1.valid_end", 32'(ov[1]), 32'd0);
      chk("t1.pending_end", 32'(op[1]), 32'd0);

      // Round robin, SIZE=5, including wrap from pointer 4.
      reqa[2] = 16'b01001;
      tick();
      clr_req();
      tick();
      chk("t2.idx_a", 32'(oi[2]), 32'd0);
      tick();
      chk("t2.idx_b", 32'(oi[2]), 32'd3);
      tick();
      reqa[2] = 16'b00011;
      tick();
      clr_req();
      tick();
      chk("t2.idx_wrap", 32'(oi[2]), 32'd0);
      tick();
      chk("t2.idx_d", 32'(oi[2]), 32'd1);
      tick();

      // Backpressure holds grant 3 while a higher-priority request arrives.
      rdy[0] = 1'b0;
      reqa[0] = 16'h0008;
      tick();
      clr_req();
      tick();
      reqa[0] = 16'h0001;
      for (int c = 0; c < 3; c++) begin
         tick();
         clr_req();
         chk("t3.hold_idx", 32'(oi[0]), 32'd3);
         chk("t3.hold_grant", 32'(og[0]), 32'h08);
      end
      rdy[0] = 1'b1;
      tick();
      chk("t3.after_release", 32'(oi[0]), 32'd0);
      tick();

      // Re-request in the cycle index 2 is retired.
      reqa[1] = 16'h0004;
      tick();
      clr_req();
      tick();
      chk("t4.presented", 32'(oi[1]), 32'd2);
      reqa[1] = 16'h0004;
      tick();
      clr_req();
      chk("t4.still_pending", 32'(op[1][2]), 32'd1);
      tick();
      chk("t4.regrant", 32'(oi[1]), 32'd2);
      tick();

      // Widest and narrowest sizes.
      reqa[3] = 16'h8000;
      tick();
      clr_req();
      tick();
      chk("t6.idx16", 32'(oi[3]), 32'hF);
      chk("t6.grant16", 32'(og[3]), 32'h8000);
      reqa[4] = 16'b11;
      tick();
      tick();
      prev = oi[4];
      chk("t6.first2", 32'(prev), 32'd0);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("t6.alternate", 32'(oi[4]), 32'(prev ^ 16'd1));
         prev = oi[4];
      end
      clr_req();
      repeat (3) tick();

      // Asynchronous reset while a grant is held.
      rdy[0] = 1'b0;
      reqa[0] = 16'h00F0;
      tick();
      clr_req();
      tick();
      chk("t5.pre_pending", 32'(op[0]), 32'hF0);
      chk("t5.pre_valid", 32'(ov[0]), 32'd1);
      #2;
      reset_n = 1'b0;
      for (int k = 0; k < NI; k++) m[k] = mzero();
      #1;
      chk("t5.rst_valid", 32'(ov[0]), 32'd0);
      chk("t5.rst_index", 32'(oi[0]), 32'd0);
      chk("t5.rst_grant", 32'(og[0]), 32'd0);
      chk("t5.rst_pending", 32'(op[0]), 32'd0);
      tick();
      @(negedge clock);
      reset_n = 1'b1;
      rdy = '1;
      repeat (4) begin
         tick();
         chk("t5.no_ghost", 32'(ov[0]), 32'd0);
      end

      // Random traffic and backpressure against the model.
      for (int it = 0; it < 2000; it++) begin
         for (int k = 0; k < NI; k++) begin
            reqa[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
            rdy[k]  = ($urandom_range(0, 3) != 0);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
